// File: rtl/comma_aligner.sv
// Word aligner ahead of the 8b/10b decoder: hunts for K28.x commas in a
// 20-bit sliding window, locks the bit offset and emits aligned code groups.

module comma_aligner_det (
  input  logic [6:0] bits,
  output logic       hit
);
  // abcdeif = 0011111 or 1100000, with a in bit 0
  assign hit = (bits == 7'b1111100) || (bits == 7'b0000011);
endmodule

module comma_aligner #(
  parameter int LOCK_CNT  = 4,
  parameter int MIS_LIMIT = 3,
  parameter int ERR_LIMIT = 8,
  parameter int GOOD_RUN  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] din,
  input  logic       din_valid,
  output logic [9:0] dout,
  output logic       dout_valid,
  output logic       dout_comma,
  output logic       locked,
  output logic [3:0] offset,
  input  logic       code_err_i,
  input  logic       code_err_valid_i
);
  localparam int NUM_OFFS = 10;

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t        state_q, state_d;
  logic [9:0]    prev_q;
  logic          prev_full_q;
  logic [3:0]    offset_q, offset_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    mis_q, mis_d;
  logic [7:0]    err_q, err_d;
  logic [7:0]    good_q, good_d;
  logic          mis_hit, err_hit;

  logic [18:0]   w;
  logic [NUM_OFFS-1:0] hit;
  logic [3:0]    hit_k, sel;
  logic          comma, act, sel_hit;
  logic [9:0]    slice;

  // Bit 19 of the window can never land in a slice, so it is not kept.
  assign w     = {din[8:0], prev_q};
  assign act   = din_valid & prev_full_q;
  assign comma = |hit;

  for (genvar k = 0; k < NUM_OFFS; k++) begin : g_det
    comma_aligner_det u_det (.bits(w[k +: 7]), .hit(hit[k]));
  end

  always_comb begin
    hit_k = 4'd0;
    for (int k = NUM_OFFS-1; k >= 0; k--)
      if (hit[k]) hit_k = 4'(k);
  end

  assign sel = (comma && state_q != LOCKED) ? hit_k : offset_q;

  always_comb begin
    slice   = w[9:0];
    sel_hit = hit[0];
    for (int k = 0; k < NUM_OFFS; k++)
      if (sel == 4'(k)) begin
        slice   = w[k +: 10];
        sel_hit = hit[k];
      end
  end

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    cnt_d    = cnt_q;
    mis_d    = mis_q;
    err_d    = err_q;
    good_d   = good_q;
    mis_hit  = 1'b0;
    err_hit  = 1'b0;
    case (state_q)
      HUNT: begin
        if (act && comma) begin
          offset_d = hit_k;
          cnt_d    = 4'd1;
          state_d  = VERIFY;
        end
      end
      VERIFY: begin
        if (act && comma) begin
          if (hit_k == offset_q) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_d == 4'(LOCK_CNT)) begin
              state_d = LOCKED;
              mis_d   = 4'd0;
              err_d   = 8'd0;
              good_d  = 8'd0;
            end
          end else begin
            offset_d = hit_k;
            cnt_d    = 4'd1;
          end
        end
      end
      LOCKED: begin
        // sel == offset here, so sel_hit means a comma at the locked offset
        if (act && comma) begin
          if (sel_hit) mis_d = 4'd0;
          else begin
            mis_d   = mis_q + 4'd1;
            mis_hit = (mis_d == 4'(MIS_LIMIT));
          end
        end
        if (code_err_valid_i) begin
          if (code_err_i) begin
            err_d   = (err_q != 8'hFF) ? err_q + 8'd1 : err_q;
            good_d  = 8'd0;
            err_hit = (err_d == 8'(ERR_LIMIT));
          end else begin
            good_d = good_q + 8'd1;
            if (good_d == 8'(GOOD_RUN)) begin
              err_d  = 8'd0;
              good_d = 8'd0;
            end
          end
        end
        if (mis_hit || err_hit) begin
          state_d = HUNT;
          cnt_d   = 4'd0;
          mis_d   = 4'd0;
          err_d   = 8'd0;
          good_d  = 8'd0;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      offset_q <= 4'd0;
      cnt_q    <= 4'd0;
      mis_q    <= 4'd0;
      err_q    <= 8'd0;
      good_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      cnt_q    <= cnt_d;
      mis_q    <= mis_d;
      err_q    <= err_d;
      good_q   <= good_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q      <= '0;
      prev_full_q <= 1'b0;
      dout        <= '0;
      dout_valid  <= 1'b0;
      dout_comma  <= 1'b0;
    end else begin
      dout_valid <= act;
      if (din_valid) begin
        prev_q      <= din;
        prev_full_q <= 1'b1;
      end
      if (act) begin
        dout       <= slice;
        dout_comma <= sel_hit;
      end
    end
  end

  assign locked = (state_q == LOCKED);
  assign offset = offset_q;

endmodule

// File: tb/tb_comma_aligner.sv
// Bench for comma_aligner: commas embedded in alternating filler at chosen
// offsets, expected words queued at drive time and checked on dout_valid.
module tb_comma_aligner;
  localparam int LOCK_CNT  = 4;
  localparam int MIS_LIMIT = 3;
  localparam int ERR_LIMIT = 8;
  localparam int GOOD_RUN  = 16;
  localparam logic [9:0] K285 = 10'b0101111100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] din = '0;
  logic       din_valid = 1'b0;
  logic       code_err_i = 1'b0;
  logic       code_err_valid_i = 1'b0;
  logic [9:0] dout;
  logic       dout_valid, dout_comma, locked;
  logic [3:0] offset;

  comma_aligner #(.LOCK_CNT(LOCK_CNT), .MIS_LIMIT(MIS_LIMIT),
                  .ERR_LIMIT(ERR_LIMIT), .GOOD_RUN(GOOD_RUN)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .dout(dout), .dout_valid(dout_valid), .dout_comma(dout_comma),
    .locked(locked), .offset(offset),
    .code_err_i(code_err_i), .code_err_valid_i(code_err_valid_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] dout;
    logic       comma;
    logic       lock;
    logic [3:0] off;
    logic       chk_dout;
  } exp_t;

  typedef struct {
    int   k;
    int   gap;
    int   npairs;
    logic exp_lock;
    int   exp_off;
  } vec_t;

  exp_t sbq[$];
  exp_t me;
  vec_t tbl[13];
  int   n_chk = 0;
  int   n_err = 0;
  logic primed = 1'b0;
  logic exp_lock = 1'b0;
  int   exp_off = 0;
  int   prev_k = -1;
  int   gap = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && dout_valid) begin
      if (sbq.size() == 0) chk("unexpected_dout_valid", dout_valid, 0);
      else begin
        me = sbq.pop_front();
        chk("dout_comma", dout_comma, me.comma);
        chk("locked", locked, me.lock);
        chk("offset", offset, me.off);
        if (me.chk_dout) chk("dout", dout, me.dout);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      din_valid = 1'b0;
    end
  endtask

  task automatic drive(input logic [9:0] w, input exp_t e);
    @(posedge clk); #1;
    din = w;
    din_valid = 1'b1;
    if (primed) sbq.push_back(e);
    primed = 1'b1;
    if (gap > 0) idle(gap);
  endtask

  // Two words carrying one K28.5 at window offset k; the comma is seen on the second.
  task automatic pair(input int k, input logic lock_after, input int off_after);
    logic [19:0] v;
    exp_t e;
    v = 20'hAAAAA;
    v[k +: 10] = K285;
    e.dout = (k % 2 == 1) ? 10'h155 : 10'h2AA;
    e.comma = 1'b0;
    e.lock = exp_lock;
    e.off = 4'(exp_off);
    e.chk_dout = (k == prev_k) && (exp_off == k);
    drive(v[9:0], e);
    e.dout = K285;
    e.comma = 1'b1;
    e.chk_dout = 1'b1;
    if (exp_lock && exp_off != k) begin
      e.comma = 1'b0;
      e.chk_dout = 1'b0;
    end
    e.lock = lock_after;
    e.off = 4'(off_after);
    drive(v[19:10], e);
    exp_lock = lock_after;
    exp_off = off_after;
    prev_k = k;
  endtask

  task automatic ev(input logic e, input int n);
    repeat (n) begin
      @(posedge clk); #1;
      code_err_valid_i = 1'b1;
      code_err_i = e;
    end
  endtask

  task automatic ev_end();
    @(posedge clk); #1;
    code_err_valid_i = 1'b0;
    code_err_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    din_valid = 1'b0;
    code_err_valid_i = 1'b0;
    code_err_i = 1'b0;
    sbq.delete();
    primed = 1'b0;
    exp_lock = 1'b0;
    exp_off = 0;
    prev_k = -1;
    gap = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dout"}, dout, 0);
    chk({tag, "_dout_valid"}, dout_valid, 0);
    chk({tag, "_dout_comma"}, dout_comma, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_offset"}, offset, 0);
  endtask

  initial begin
    for (int i = 0; i < 10; i++) tbl[i] = '{i, 0, 5, 1'b1, i};
    tbl[10] = '{6, 2, 5, 1'b1, 6};
    tbl[11] = '{3, 2, 4, 1'b1, 3};
    tbl[12] = '{9, 0, 3, 1'b0, 9};

    #3;
    chk_zero("reset");
    do_reset();

    // offset sweep, continuous and 1-in-3 gapped
    for (int r = 0; r < 13; r++) begin
      do_reset();
      gap = tbl[r].gap;
      for (int p = 1; p <= tbl[r].npairs; p++) pair(tbl[r].k, p >= LOCK_CNT, tbl[r].k);
      gap = 0;
      idle(3);
      chk("sweep_locked", locked, tbl[r].exp_lock);
      chk("sweep_offset", offset, tbl[r].exp_off);
      chk("sweep_pending", sbq.size(), 0);
    end

    // restart in VERIFY
    do_reset();
    pair(3, 0, 3); pair(3, 0, 3);
    pair(7, 0, 7); pair(7, 0, 7); pair(7, 0, 7);
    pair(7, 1, 7);
    idle(3);
    chk("restart_locked", locked, 1);
    chk("restart_offset", offset, 7);
    chk("restart_pending", sbq.size(), 0);

    // misalignment while locked
    do_reset();
    for (int p = 1; p <= 4; p++) pair(2, p >= LOCK_CNT, 2);
    pair(5, 1, 2); pair(5, 1, 2);
    pair(2, 1, 2);
    pair(5, 1, 2); pair(5, 1, 2); pair(5, 0, 2);
    for (int p = 1; p <= 4; p++) pair(5, p >= LOCK_CNT, 5);
    idle(3);
    chk("mis_relock", locked, 1);
    chk("mis_offset", offset, 5);
    chk("mis_pending", sbq.size(), 0);

    // decoder error accounting
    do_reset();
    for (int p = 1; p <= 4; p++) pair(4, p >= LOCK_CNT, 4);
    idle(2);
    chk("err_lock_start", locked, 1);
    for (int i = 0; i < 7; i++) begin
      ev(1'b1, 1);
      ev(1'b0, 15);
    end
    ev_end();
    chk("err7_interleaved", locked, 1);
    ev(1'b0, 1);
    ev(1'b1, 7);
    ev_end();
    chk("err7_after_clear", locked, 1);
    ev(1'b1, 1);
    chk("err8_before_edge", locked, 1);
    ev_end();
    chk("err8_drop", locked, 0);

    // asynchronous reset mid-stream
    do_reset();
    for (int p = 1; p <= 5; p++) pair(1, p >= LOCK_CNT, 1);
    @(posedge clk); #2;
    chk("pre_rst_valid", dout_valid, 1);
    chk("pre_rst_locked", locked, 1);
    rst_n = 1'b0;
    din_valid = 1'b0;
    #1;
    chk_zero("midrst");
    do_reset();
    pair(1, 0, 1);
    idle(3);
    chk("post_rst_offset", offset, 1);
    chk("post_rst_pending", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/comma_aligner.md
# comma_aligner

Word-alignment stage ahead of the 8b/10b decoder. Takes unaligned 10-bit words from the deserializer and searches a 20-bit sliding window for the K28.x comma (abcdeif = 0011111 or 1100000). It locks the bit offset after repeated consistent commas, then emits aligned 10-bit code groups in decoder bit order (bit 0 = a … bit 9 = j). Lock is dropped on persistent comma misplacement or decoder code errors reported back from the decoder.

## Interface

Parameters:
- LOCK_CNT, 4: consecutive commas at the same offset needed to lock (2..15).
- MIS_LIMIT, 3: consecutive in-lock commas at a wrong offset that force re-hunt (1..15).
- ERR_LIMIT, 8: accumulated decoder code errors, while locked, that force re-hunt (1..255).
- GOOD_RUN, 16: consecutive error-free decoded words that clear the error count (1..255).

Ports:
- clk  in  1  single clock for the whole block.
- rst_n  in  1  asynchronous active-low reset.
- din  in  10  raw deserializer word; din[0] is the earliest-received bit.
- din_valid  in  1  din is a new word this cycle.
- dout  out  10  aligned code group, bit 0 = a, bit 5 = i, bit 9 = j; feeds decoder datain.
- dout_valid  out  1  dout holds a new aligned word.
- dout_comma  out  1  dout contains a comma pattern at bits [6:0].
- locked  out  1  alignment acquired.
- offset  out  4  current bit offset, 0..9.
- code_err_i  in  1  decoder code_err for a previously emitted word.
- code_err_valid_i  in  1  qualifies code_err_i; one pulse per decoded word.

## Operation

- Window: prev_q[9:0] holds the previous valid din. The window is w[19:0] = {din, prev_q}, so w[0] is the earliest bit. Both update only on din_valid.
- prev_full_q is set on the first din_valid after reset. No output is produced until it is set.
- Comma at offset k (k = 0..9): w[k+6:k] == 7'b1111100 or 7'b0000011. If several offsets match, the lowest k wins (hit_k).
- Slice select: sel = hit_k when a comma is present and state is HUNT or VERIFY; otherwise sel = offset. dout <= w[sel+9:sel].
- States:
  - HUNT: locked = 0. A comma sets offset <= hit_k, cnt <= 1, and moves to VERIFY.
  - VERIFY: a comma at hit_k == offset increments cnt. When cnt reaches LOCK_CNT, go to LOCKED and clear the misalign and error counters.
  - VERIFY: a comma at another offset restarts verification: offset <= hit_k, cnt <= 1.
  - VERIFY: non-comma words leave state and cnt unchanged.
  - LOCKED: locked = 1 and offset is frozen. A comma found only at offsets ≠ offset increments mis_cnt. A comma at offset clears mis_cnt.
  - LOCKED: mis_cnt reaching MIS_LIMIT → HUNT.
- Error tracking, LOCKED only, on code_err_valid_i:
  - code_err_i = 1: err_cnt +1 (saturating) and good_cnt <= 0.
  - code_err_i = 0: good_cnt +1. When good_cnt reaches GOOD_RUN, err_cnt <= 0 and good_cnt <= 0.
  - err_cnt reaching ERR_LIMIT → HUNT.
  - code_err_valid_i is ignored outside LOCKED.
- Going to HUNT clears cnt, mis_cnt, err_cnt and good_cnt. offset keeps its last value.
- Simultaneous events in LOCKED: MIS_LIMIT and ERR_LIMIT hit in the same cycle → single transition to HUNT. A comma at offset in the same cycle as an error still clears mis_cnt.

## Timing

- Reset values: dout = 0, dout_valid = 0, dout_comma = 0, locked = 0, offset = 0, state = HUNT, all counters 0, prev_full_q = 0.
- Reset is asynchronous and applies immediately mid-stream. Internal state is discarded and the first post-reset word only fills prev_q.
- Latency: din_valid at cycle n (with prev_full_q set) → dout_valid = 1 at n+1, holding the window slice from cycle n. dout_valid is a one-cycle pulse per din_valid.
- dout_comma is registered with dout and reflects a comma at the selected slice.
- locked rises the cycle after the LOCK_CNT-th comma's dout_valid register edge, i.e. with that word's dout_valid. locked falls the cycle after the triggering event.
- The comma word that first selects a new offset in HUNT/VERIFY is itself emitted aligned.

## Test plan

- Offset sweep: for each k = 0..9, shift a K28.5 RD- / D21.5 stream by k bits. Required: after 4 commas, locked = 1 and offset = k. Every dout_comma word reads 10'b0101111100.
- Restart in VERIFY: 2 commas at offset 3, then a comma at offset 7. Required: offset = 7, locked stays 0, and lock occurs 3 commas later.
- Misalignment: locked at offset 2, then 2 commas at offset 5, one at offset 2, then 3 at offset 5. Required: locked stays 1 until the third consecutive offset-5 comma. It drops one cycle later, and re-locks at 5 after 4 more commas.
- Error count: locked, drive 7 errors interleaved with 15-word clean runs → stays locked. A 16-word clean run clears the count; 8 errors without a 16-word clean run → locked = 0.
- Reset mid-stream: assert rst_n low while locked with dout_valid active. Required: all outputs 0 immediately. After release, the first din_valid gives no dout_valid and the second gives dout_valid = 1.
- Gapped input: din_valid at a 1-in-3 duty. Required: identical dout sequence to the continuous case, with dout_valid only the cycle after each din_valid.
